// File: rtl/sub_nibble_seq_pkg.sv
// rtl/sub_nibble_seq_pkg.sv - shared constants and state encoding for the nibble-serial subtractor
package sub_nibble_seq_pkg;

    localparam int NIB = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SUB  = 2'd1,
        ST_FIX  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Nibble index width; a single-nibble operand still needs a 1-bit counter.
    function automatic int idx_width(input int nnib);
        return (nnib > 1) ? $clog2(nnib) : 1;
    endfunction

endpackage

// File: rtl/nibble_add4.sv
// rtl/nibble_add4.sv - combinational 4-bit ripple adder built from full adders
module nibble_add4 (
    output logic [3:0] s,
    output logic       cout,
    input  logic [3:0] x,
    input  logic [3:0] y,
    input  logic       cin
);

    logic [4:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[4];

endmodule

// File: rtl/sub_nibble_seq.sv
// rtl/sub_nibble_seq.sv - sequencer computing |a-b| and sign through one shared 4-bit adder slice
module sub_nibble_seq
    import sub_nibble_seq_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             neg
);

    localparam int NNIB = WIDTH / NIB;
    localparam int IW   = idx_width(NNIB);

    state_t           state;
    state_t           state_nx;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] r_r;
    logic [WIDTH-1:0] r_upd;
    logic [IW-1:0]    idx;
    logic             carry;
    logic             neg_r;
    logic             last;
    logic [NIB-1:0]   x;
    logic [NIB-1:0]   y;
    logic [NIB-1:0]   s;
    logic             co;

    assign last = (idx == IW'(NNIB - 1));

    // Pass 1 feeds a + ~b; the fix-up pass negates the stored result (~r + carry-in).
    always_comb begin
        if (state == ST_FIX) begin
            x = ~r_r[NIB*idx +: NIB];
            y = '0;
        end else begin
            x = a_r[NIB*idx +: NIB];
            y = ~b_r[NIB*idx +: NIB];
        end
    end

    nibble_add4 u_add (
        .s    (s),
        .cout (co),
        .x    (x),
        .y    (y),
        .cin  (carry)
    );

    always_comb begin
        r_upd = r_r;
        r_upd[NIB*idx +: NIB] = s;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            ST_IDLE: if (start) state_nx = ST_SUB;
            ST_SUB:  if (last)  state_nx = co ? ST_DONE : ST_FIX;
            ST_FIX:  if (last)  state_nx = ST_DONE;
            ST_DONE: state_nx = ST_IDLE;
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            a_r   <= '0;
            b_r   <= '0;
            r_r   <= '0;
            idx   <= '0;
            carry <= 1'b0;
            neg_r <= 1'b0;
            diff  <= '0;
            neg   <= 1'b0;
        end else begin
            state <= state_nx;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        idx   <= '0;
                        carry <= 1'b1;
                    end
                end
                ST_SUB: begin
                    r_r <= r_upd;
                    if (last) begin
                        // Final pass-1 carry only picks the sign; it never reaches diff.
                        idx   <= '0;
                        carry <= 1'b1;
                        neg_r <= ~co;
                        if (co) begin
                            diff <= r_upd;
                            neg  <= 1'b0;
                        end
                    end else begin
                        idx   <= idx + 1'b1;
                        carry <= co;
                    end
                end
                ST_FIX: begin
                    r_r   <= r_upd;
                    carry <= co;
                    if (last) begin
                        idx  <= '0;
                        diff <= r_upd;
                        neg  <= neg_r;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != ST_IDLE);
    assign done = (state == ST_DONE);

endmodule
